// File: rtl/carry_resolve_seq.sv
// Iterative carry resolver: folds a carry-save (sum, carry) pair into one binary
// result by re-applying a half-adder rank once per clock until no carries remain.
module carry_resolve_seq #(
    parameter int unsigned N  = 4,
    parameter int unsigned CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  sum_in,
    input  logic [N-1:0]  carry_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N+1:0]  result,
    output logic [CW-1:0] iters
);

    localparam int unsigned W = N + 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESOLVE = 2'd1,
        DONE    = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  s_q, s_d;
    logic [W-1:0]  c_q, c_d;
    logic [W-1:0]  result_q, result_d;
    logic [CW-1:0] iters_q, iters_d;

    // State and datapath registers; reset wins over any handshake on the same edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            s_q      <= '0;
            c_q      <= '0;
            result_q <= '0;
            iters_q  <= '0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            c_q      <= c_d;
            result_q <= result_d;
            iters_q  <= iters_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        c_d      = c_q;
        result_d = result_q;
        iters_d  = iters_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    s_d     = {2'b00, sum_in};
                    c_d     = {1'b0, carry_in, 1'b0};
                    iters_d = '0;
                    state_d = RESOLVE;
                end
            end
            RESOLVE: begin
                if (c_q == '0) begin
                    result_d = s_q;
                    state_d  = DONE;
                end else begin
                    s_d     = s_q ^ c_q;
                    // Carry out of the top bit is always 0 since the true sum fits in W bits
                    c_d     = {s_q[W-2:0] & c_q[W-2:0], 1'b0};
                    iters_d = iters_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign iters     = iters_q;

endmodule

// File: tb/tb_carry_resolve_seq.sv
// Self-checking bench for carry_resolve_seq (N=4): directed plan cases plus
// randomized operands against an arithmetic reference model.
module tb_carry_resolve_seq;

    localparam int unsigned N  = 4;
    localparam int unsigned CW = 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  sum_in;
    logic [N-1:0]  carry_in;
    logic          out_valid;
    logic          out_ready;
    logic [N+1:0]  result;
    logic [CW-1:0] iters;

    int checks = 0;
    int errors = 0;

    carry_resolve_seq #(.N(N), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_in    (sum_in),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .iters     (iters)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference value: the plain arithmetic sum the block must produce
    function automatic int ref_result(input int s, input int c);
        return s + 2 * c;
    endfunction

    // Reference iteration count: repeated half-adder ranks on integers
    function automatic int ref_iters(input int s, input int c);
        int k;
        int cc;
        int ss;
        int t;
        k  = 0;
        ss = s;
        cc = c * 2;
        while (cc != 0) begin
            t  = ss ^ cc;
            cc = ((ss & cc) * 2) % 64;
            ss = t;
            k++;
        end
        return k;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input int s, input int c);
        in_valid = 1'b1;
        sum_in   = N'(s);
        carry_in = N'(c);
        step();
        in_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid is seen; bounded
    task automatic wait_done(output int lat, output bit timed_out);
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        timed_out = !out_valid;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
        checks++;
        if (result !== 6'd0 || iters !== 4'd0) begin
            errors++;
            $display("FAIL reset_data: result=%0d iters=%0d expected 0/0", result, iters);
        end
    endtask

    // Directed single operand: checks value, iteration count and latency
    task automatic test_directed(input string name, input int s, input int c,
                                 input int exp_res, input int exp_it);
        int lat;
        bit to;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready: in_ready=%b expected 1", name, in_ready);
        end
        start_op(s, c);
        wait_done(lat, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL %s_timeout: out_valid never rose, expected after %0d edges", name, exp_it + 1);
        end
        checks++;
        if (result !== 6'(exp_res) || iters !== 4'(exp_it)) begin
            errors++;
            $display("FAIL %s_value: result=%0d iters=%0d expected %0d/%0d", name, result, iters, exp_res, exp_it);
        end
        checks++;
        if (lat != exp_it + 1) begin
            errors++;
            $display("FAIL %s_latency: out_valid after %0d edges expected %0d", name, lat, exp_it + 1);
        end
        release_out();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_release: out_valid=%b in_ready=%b expected 0/1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_idle_hold();
        in_valid = 1'b0;
        sum_in   = 4'b1011;
        carry_in = 4'b0110;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 6'd45) begin
            errors++;
            $display("FAIL idle_hold: in_ready=%b out_valid=%b result=%0d expected 1/0/45", in_ready, out_valid, result);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bit to;
        int bad;
        start_op(4'b1110, 4'b0001);
        wait_done(lat, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL bp_timeout: out_valid never rose, expected after 5 edges");
        end
        in_valid = 1'b1;
        sum_in   = 4'b0011;
        carry_in = 4'b0101;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 6'd16 || iters !== 4'd4) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: %0d stalled cycles unstable, last out_valid=%b in_ready=%b result=%0d iters=%0d expected 1/0/16/4",
                     bad, out_valid, in_ready, result, iters);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 6'd16) begin
            errors++;
            $display("FAIL bp_idle: in_ready=%b out_valid=%b result=%0d expected 1/0/16", in_ready, out_valid, result);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_accept: in_ready=%b expected 0 after accept", in_ready);
        end
        wait_done(lat, to);
        checks++;
        if (to || result !== 6'(ref_result(3, 5)) || iters !== 4'(ref_iters(3, 5))) begin
            errors++;
            $display("FAIL bp_next: result=%0d iters=%0d timeout=%b expected %0d/%0d/0",
                     result, iters, to, ref_result(3, 5), ref_iters(3, 5));
        end
        release_out();
    endtask

    task automatic test_reset_mid();
        int seen;
        start_op(4'b1110, 4'b0001);
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || result !== 6'd0 || iters !== 4'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: out_valid=%b result=%0d iters=%0d in_ready=%b expected 0/0/0/1",
                     out_valid, result, iters, in_ready);
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_mid_pulse: out_valid seen %0d cycles expected 0", seen);
        end
    endtask

    task automatic test_stream();
        int ops_s[3] = '{3, 0, 10};
        int ops_c[3] = '{0, 7, 5};
        int sb[$];
        int lat;
        bit to;
        int exp;
        for (int i = 0; i < 3; i++) sb.push_back(ref_result(ops_s[i], ops_c[i]));
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sum_in   = N'(ops_s[i]);
            carry_in = N'(ops_c[i]);
            step();
            wait_done(lat, to);
            exp = sb.pop_front();
            checks++;
            if (to || result !== 6'(exp)) begin
                errors++;
                $display("FAIL stream_%0d: result=%0d timeout=%b expected %0d", i, result, to, exp);
            end
            step();
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL stream_idle_%0d: in_ready=%b out_valid=%b expected 1/0", i, in_ready, out_valid);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        int s;
        int c;
        int lat;
        int stall;
        int bad;
        bit to;
        for (int n = 0; n < 40; n++) begin
            s = int'($urandom_range(0, 15));
            c = int'($urandom_range(0, 15));
            start_op(s, c);
            wait_done(lat, to);
            checks++;
            if (to || result !== 6'(ref_result(s, c)) || iters !== 4'(ref_iters(s, c))
                || lat != ref_iters(s, c) + 1) begin
                errors++;
                $display("FAIL random s=%0d c=%0d: result=%0d iters=%0d lat=%0d expected %0d/%0d/%0d",
                         s, c, result, iters, lat, ref_result(s, c), ref_iters(s, c), ref_iters(s, c) + 1);
            end
            stall = int'($urandom_range(0, 3));
            bad = 0;
            for (int i = 0; i < stall; i++) begin
                step();
                if (out_valid !== 1'b1 || result !== 6'(ref_result(s, c))) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL random_stall s=%0d c=%0d: %0d unstable cycles, result=%0d expected %0d",
                         s, c, bad, result, ref_result(s, c));
            end
            release_out();
        end
    endtask

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sum_in    = '0;
        carry_in  = '0;
        #1;
        test_reset();
        test_directed("no_carry", 4'b0101, 4'b0000, 5, 0);
        test_directed("ripple",   4'b1110, 4'b0001, 16, 4);
        test_directed("double",   4'b1111, 4'b1111, 45, 3);
        test_idle_hold();
        test_backpressure();
        test_reset_mid();
        test_stream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
